// File: rtl/semaphore_pkg.sv
// rtl/semaphore_pkg.sv - shared state codes and lamp decode for the semaphore and intersection blocks
package semaphore_pkg;

    localparam logic [7:0] IC_OFF  = 8'h01;
    localparam logic [7:0] IC_NS_G = 8'h02;
    localparam logic [7:0] IC_NS_Y = 8'h04;
    localparam logic [7:0] IC_AR1  = 8'h08;
    localparam logic [7:0] IC_EW_G = 8'h10;
    localparam logic [7:0] IC_EW_Y = 8'h20;
    localparam logic [7:0] IC_AR2  = 8'h40;
    localparam logic [7:0] IC_PED  = 8'h80;

    // Single-semaphore codes, kept here so every bench shares one definition.
    localparam logic [3:0] SEM_OFF    = 4'b0001;
    localparam logic [3:0] SEM_RED    = 4'b0010;
    localparam logic [3:0] SEM_YELLOW = 4'b0100;
    localparam logic [3:0] SEM_GREEN  = 4'b1000;

    typedef enum logic [7:0] {
        ST_OFF  = IC_OFF,
        ST_NS_G = IC_NS_G,
        ST_NS_Y = IC_NS_Y,
        ST_AR1  = IC_AR1,
        ST_EW_G = IC_EW_G,
        ST_EW_Y = IC_EW_Y,
        ST_AR2  = IC_AR2,
        ST_PED  = IC_PED
    } ic_state_t;

    typedef struct packed {
        logic ns_red;
        logic ns_yellow;
        logic ns_green;
        logic ew_red;
        logic ew_yellow;
        logic ew_green;
        logic walk;
    } lamps_t;

    function automatic lamps_t lamp_decode(input ic_state_t st);
        lamps_t l;
        l = '0;
        case (st)
            ST_NS_G: begin l.ns_green  = 1'b1; l.ew_red = 1'b1; end
            ST_NS_Y: begin l.ns_yellow = 1'b1; l.ew_red = 1'b1; end
            ST_AR1,
            ST_AR2:  begin l.ns_red    = 1'b1; l.ew_red = 1'b1; end
            ST_EW_G: begin l.ew_green  = 1'b1; l.ns_red = 1'b1; end
            ST_EW_Y: begin l.ew_yellow = 1'b1; l.ns_red = 1'b1; end
            ST_PED:  begin l.ns_red = 1'b1; l.ew_red = 1'b1; l.walk = 1'b1; end
            default: l = '0;
        endcase
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - per-state phase counter with terminal-count flag
module phase_timer
    import semaphore_pkg::*;
#(
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic [7:0] state,
    output logic       done
);

    localparam longint MAX_CNT = (64'd1 << CNT_W) - 64'd1;

    if (GREEN_TICKS < 1 || YELLOW_TICKS < 1 || ALLRED_TICKS < 1 || WALK_TICKS < 1 ||
        longint'(GREEN_TICKS - 1)  > MAX_CNT || longint'(YELLOW_TICKS - 1) > MAX_CNT ||
        longint'(ALLRED_TICKS - 1) > MAX_CNT || longint'(WALK_TICKS - 1)   > MAX_CNT) begin : g_bad_ticks
        $error("phase_timer: every *_TICKS must be >= 1 and TICKS-1 must fit in CNT_W bits");
    end

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] limit;

    always_comb begin
        limit = '0;
        case (state)
            IC_NS_G, IC_EW_G: limit = CNT_W'(GREEN_TICKS - 1);
            IC_NS_Y, IC_EW_Y: limit = CNT_W'(YELLOW_TICKS - 1);
            IC_AR1, IC_AR2:   limit = CNT_W'(ALLRED_TICKS - 1);
            IC_PED:           limit = CNT_W'(WALK_TICKS - 1);
            default:          limit = '0;
        endcase
    end

    always_comb begin
        count_d = clr ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == limit);

endmodule

// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - two-way intersection sequencer with clearance and pedestrian phases
module intersection_controller
    import semaphore_pkg::*;
#(
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int WALK_TICKS   = 10,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       ped_req,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       walk,
    output logic       ped_pending,
    output logic [7:0] state_out
);

    ic_state_t state_q, state_d;
    logic      pend_q, pend_d;
    lamps_t    lamps_q, lamps_d;
    logic      phase_done;
    logic      timer_clr;

    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:  state_d = ST_AR2;
                ST_NS_G: if (phase_done) state_d = ST_NS_Y;
                ST_NS_Y: if (phase_done) state_d = ST_AR1;
                ST_AR1:  if (phase_done) state_d = ST_EW_G;
                ST_EW_G: if (phase_done) state_d = ST_EW_Y;
                ST_EW_Y: if (phase_done) state_d = ST_AR2;
                ST_AR2:  if (phase_done) state_d = pend_q ? ST_PED : ST_NS_G;
                ST_PED:  if (phase_done) state_d = ST_NS_G;
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Holding the timer at zero in OFF keeps it from wrapping while parked.
    always_comb begin
        timer_clr = (state_d != state_q) || (state_q == ST_OFF);
    end

    // Entering PED consumes the request; a press on that same edge is part of it.
    always_comb begin
        pend_d = (pend_q | ped_req) & ~((state_d == ST_PED) && (state_q != ST_PED));
    end

    always_comb begin
        lamps_d = lamp_decode(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_OFF;
            pend_q  <= 1'b0;
            lamps_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            lamps_q <= lamps_d;
        end
    end

    phase_timer #(
        .GREEN_TICKS  (GREEN_TICKS),
        .YELLOW_TICKS (YELLOW_TICKS),
        .ALLRED_TICKS (ALLRED_TICKS),
        .WALK_TICKS   (WALK_TICKS),
        .CNT_W        (CNT_W)
    ) u_phase_timer (
        .clk   (clk),
        .rst_n (reset_n),
        .clr   (timer_clr),
        .state (state_q),
        .done  (phase_done)
    );

    assign ns_red      = lamps_q.ns_red;
    assign ns_yellow   = lamps_q.ns_yellow;
    assign ns_green    = lamps_q.ns_green;
    assign ew_red      = lamps_q.ew_red;
    assign ew_yellow   = lamps_q.ew_yellow;
    assign ew_green    = lamps_q.ew_green;
    assign walk        = lamps_q.walk;
    assign ped_pending = pend_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_intersection_controller.sv
// tb/tb_intersection_controller.sv - directed vector bench for intersection_controller
module tb_intersection_controller;

    localparam logic [7:0] S_OFF = 8'h01, S_NSG = 8'h02, S_NSY = 8'h04, S_AR1 = 8'h08;
    localparam logic [7:0] S_EWG = 8'h10, S_EWY = 8'h20, S_AR2 = 8'h40, S_PED = 8'h80;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       ped_req = 1'b0;
    logic       ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
    logic       ped_pending;
    logic [7:0] state_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic       req;
        logic [7:0] st;
        logic       pend;
    } vec_t;

    vec_t vecs[$];

    intersection_controller #(
        .GREEN_TICKS  (5),
        .YELLOW_TICKS (2),
        .ALLRED_TICKS (1),
        .WALK_TICKS   (3),
        .CNT_W        (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .ped_req     (ped_req),
        .ns_red      (ns_red),
        .ns_yellow   (ns_yellow),
        .ns_green    (ns_green),
        .ew_red      (ew_red),
        .ew_yellow   (ew_yellow),
        .ew_green    (ew_green),
        .walk        (walk),
        .ped_pending (ped_pending),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk}
    function automatic logic [6:0] model_lamps(input logic [7:0] st);
        case (st)
            S_NSG:   return 7'b001_100_0;
            S_NSY:   return 7'b010_100_0;
            S_AR1:   return 7'b100_100_0;
            S_AR2:   return 7'b100_100_0;
            S_EWG:   return 7'b100_001_0;
            S_EWY:   return 7'b100_010_0;
            S_PED:   return 7'b100_100_1;
            default: return 7'b000_000_0;
        endcase
    endfunction

    task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int idx, input logic [7:0] st, input logic pend);
        logic [6:0] lamps;
        lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};
        check({tag, "_state"}, idx, state_out, st);
        check({tag, "_lamps"}, idx, {1'b0, lamps}, {1'b0, model_lamps(st)});
        check({tag, "_pending"}, idx, {7'b0, ped_pending}, {7'b0, pend});
    endtask

    task automatic push(input logic en, input logic req, input logic [7:0] st, input logic pend, input int n);
        vec_t v;
        v.en = en; v.req = req; v.st = st; v.pend = pend;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        // Start-up: one clearance cycle, then a full plain cycle with a request during EW_G
        push(1, 0, S_AR2, 0, 1);
        push(1, 0, S_NSG, 0, 5);
        push(1, 0, S_NSY, 0, 2);
        push(1, 0, S_AR1, 0, 1);
        push(1, 0, S_EWG, 0, 1);
        push(1, 1, S_EWG, 1, 1);
        push(1, 0, S_EWG, 1, 3);
        push(1, 0, S_EWY, 1, 2);
        push(1, 0, S_AR2, 1, 1);
        push(1, 0, S_PED, 0, 3);
        push(1, 0, S_NSG, 0, 5);
        push(1, 0, S_NSY, 0, 2);
        push(1, 0, S_AR1, 0, 1);
        push(1, 0, S_EWG, 0, 5);
        push(1, 0, S_EWY, 0, 1);
        // ped_req held across the AR2->PED edge: clear wins, PED not repeated
        push(1, 1, S_EWY, 1, 1);
        push(1, 1, S_AR2, 1, 1);
        push(1, 1, S_PED, 0, 1);
        push(1, 0, S_PED, 0, 2);
        push(1, 0, S_NSG, 0, 5);
        push(1, 0, S_NSY, 0, 2);
        push(1, 0, S_AR1, 0, 1);
        // Request latched mid-PED is served after the following AR2
        push(1, 1, S_EWG, 1, 1);
        push(1, 0, S_EWG, 1, 4);
        push(1, 0, S_EWY, 1, 2);
        push(1, 0, S_AR2, 1, 1);
        push(1, 0, S_PED, 0, 1);
        push(1, 1, S_PED, 1, 1);
        push(1, 0, S_PED, 1, 1);
        push(1, 0, S_NSG, 1, 5);
        push(1, 0, S_NSY, 1, 2);
        push(1, 0, S_AR1, 1, 1);
        push(1, 0, S_EWG, 1, 5);
        push(1, 0, S_EWY, 1, 2);
        push(1, 0, S_AR2, 1, 1);
        push(1, 0, S_PED, 0, 3);
        // Plain AR2 -> NS_G, then disable during NS_Y
        push(1, 0, S_NSG, 0, 5);
        push(1, 0, S_NSY, 0, 2);
        push(1, 0, S_AR1, 0, 1);
        push(1, 0, S_EWG, 0, 5);
        push(1, 0, S_EWY, 0, 2);
        push(1, 0, S_AR2, 0, 1);
        push(1, 0, S_NSG, 0, 5);
        push(1, 0, S_NSY, 0, 1);
        push(0, 0, S_OFF, 0, 10);
        push(1, 0, S_AR2, 0, 1);
        push(1, 0, S_NSG, 0, 5);
        push(1, 0, S_NSY, 0, 2);
        push(1, 0, S_AR1, 0, 1);
        push(1, 1, S_EWG, 1, 1);
        push(1, 0, S_EWG, 1, 1);

        // Reset held with enable high
        reset_n = 1'b0;
        enable  = 1'b1;
        ped_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset", 0, S_OFF, 1'b0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            enable  = vecs[i].en;
            ped_req = vecs[i].req;
            @(posedge clk);
            #1;
            check_outputs("seq", i, vecs[i].st, vecs[i].pend);
        end
        ped_req = 1'b0;

        // Asynchronous reset between edges during EW_G with a request pending
        #3;
        reset_n = 1'b0;
        #1;
        check_outputs("async_rst", 0, S_OFF, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("async_rst_hold", 1, S_OFF, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("async_rst_restart", 2, S_AR2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
